mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one serialMultiplier between NREQ requesters. Round-robin arbitration picks a pending
//  request, latches its operands, pulses the multiplier Enable for one cycle, waits for done, and
//  returns the product to the winner with a one-cycle ack. A watchdog flags a multiplier hang.
//  Sits between client blocks and the single serialMultiplier instance.
// PARAMETERS
//  WIDTH    4    operand width; product is 2*WIDTH
//  NREQ     4    number of requesters (2..8)
//  TIMEOUT  64   max cycles in WAIT before error is declared (>= 2*WIDTH+4)
// PORTS
//  clk           in   1            system clock, all logic on posedge
//  reset         in   1            asynchronous, active-LOW reset
//  req           in   NREQ         level request per client; hold until ack
//  op_a          in   NREQ*WIDTH   multiplicand, client i in [i*WIDTH +: WIDTH]
//  op_b          in   NREQ*WIDTH   multiplier, same packing
//  ack           out  NREQ         one-hot, 1-cycle pulse: result/err valid for that client
//  result        out  2*WIDTH      product, valid when any ack bit is high
//  err           out  1            high with ack if the job timed out (result then 0)
//  busy          out  1            high in every state except IDLE
//  mult_en       out  1            to multiplier Enable; 1-cycle pulse
//  multiplicant  out  WIDTH        to multiplier; held stable from ISSUE until RESP
//  multiplier    out  WIDTH        to multiplier; held stable from ISSUE until RESP
//  mult_product  in   2*WIDTH      from multiplier product
//  mult_done     in   1            from multiplier done
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, ack=0, result=0, err=0, busy=0, mult_en=0,
//   multiplicant=0, multiplier=0, rr pointer=0, watchdog=0. Reset mid-job abandons it; no ack.
//  States: IDLE -> ISSUE -> WAIT -> RESP -> DRAIN -> IDLE.
//  IDLE: if |req, grant = first set req bit searching from rr pointer upward (wrapping);
//   latch op_a/op_b slice of grant into multiplicant/multiplier; go ISSUE. Else stay.
//  ISSUE: mult_en=1 for exactly this cycle; clear watchdog; go WAIT.
//  WAIT: if mult_done=1 -> latch mult_product into result, err=0, go RESP.
//   Else watchdog++; when watchdog reaches TIMEOUT-1 -> result=0, err=1, go RESP.
//  RESP: ack[grant]=1 for one cycle with result/err; rr pointer = grant+1 (mod NREQ); go DRAIN.
//  DRAIN: wait for mult_done=0 (or immediately if err set); then IDLE. Prevents stale done
//   from completing the next job. DRAIN also times out after TIMEOUT cycles -> IDLE.
//  result/err hold their value after RESP until next RESP; only ack qualifies them.
//  Latency: req seen in IDLE -> mult_en 1 cycle later -> ack 1 cycle after done sampled.
//  Fairness: winner gets lowest priority next round; a client that keeps req high is
//   served at most once per NREQ grants while others wait.
//  req changes during a job do not affect the granted job (operands already latched).
//  A client dropping req before ack is still acked (job completes).
//  Simultaneous req from all clients after reset: client 0 first, then 1,2,3,0,...
//  Product width 2*WIDTH: max 15*15=225 fits in 8 bits for WIDTH=4; no truncation.
// TESTING
//  1 Reset: drive reset=0 mid-WAIT with req=4'b0001 -> all outputs 0, state IDLE, no ack ever.
//  2 Single job: req[2]=1, op_a[2]=13, op_b[2]=11 -> one mult_en pulse, multiplicant=13,
//    multiplier=11, ack=4'b0100 with result=143, err=0.
//  3 Round-robin: req=4'b1111 held, distinct operands -> ack order 0,1,2,3,0; each result
//    matches its client's a*b; exactly one mult_en per ack.
//  4 Corners: operands 0*x and 15*15 -> results 0 and 225; 50 random pairs vs a*b golden.
//  5 Timeout: model never raises mult_done -> ack after TIMEOUT cycles in WAIT, err=1,
//    result=0; next request is served normally.
//  6 Sticky done: model holds mult_done high 5 cycles past ack -> no second ack, next
//    mult_en only after mult_done falls.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one serial multiplier between NREQ clients. A round-robin search
//   starting at rr_ptr picks a requester. Its operands are latched, the
//   multiplier gets a one-cycle enable, and the product is returned with a
//   one-cycle ack to the winning client. A watchdog ends a job whose done
//   never arrives and reports it through err.
//
//   clk           system clock
//   reset         asynchronous, active-low reset
//   req           per-client level request, held until ack
//   op_a, op_b    packed client operands, client i at [i*WIDTH +: WIDTH]
//   ack           one-hot, one-cycle pulse qualifying result/err
//   result        product of the acked job (0 on timeout), held until next ack
//   err           set with ack when the job timed out
//   busy          high whenever the arbiter is not idle
//   mult_en       one-cycle enable to the multiplier
//   multiplicant  operand A to the multiplier, stable for the whole job
//   multiplier    operand B to the multiplier, stable for the whole job
//   mult_product  product from the multiplier
//   mult_done     done from the multiplier
//
//   state   | meaning
//   IDLE    | no job; pick the next requester
//   ISSUE   | mult_en high; watchdog cleared
//   WAIT    | waiting for mult_done or for the watchdog to expire
//   RESP    | ack visible to the winner; advance rr_ptr
//   DRAIN   | wait for a lingering mult_done to drop before the next job
module mult_share_arbiter #(
    parameter int WIDTH   = 4,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   op_a,
    input  logic [NREQ*WIDTH-1:0]   op_b,
    output logic [NREQ-1:0]         ack,
    output logic [2*WIDTH-1:0]      result,
    output logic                    err,
    output logic                    busy,
    output logic                    mult_en,
    output logic [WIDTH-1:0]        multiplicant,
    output logic [WIDTH-1:0]        multiplier,
    input  logic [2*WIDTH-1:0]      mult_product,
    input  logic                    mult_done
);

    localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [GW-1:0]  LAST_CLIENT = GW'(NREQ - 1);
    localparam logic [WDW-1:0] WD_LAST     = WDW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t         state;
    logic [GW-1:0]  grant;
    logic [GW-1:0]  rr_ptr;
    logic [GW-1:0]  pick;
    logic [GW:0]    idx;
    logic [WDW-1:0] watchdog;

    // Search from the farthest offset down to offset 0 so the last hit,
    // which is the one that sticks, is the requester nearest to rr_ptr.
    always_comb begin
        pick = rr_ptr;
        idx  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr} + (GW+1)'(i);
            if (idx >= (GW+1)'(NREQ)) begin
                idx = idx - (GW+1)'(NREQ);
            end
            if (req[idx[GW-1:0]]) begin
                pick = idx[GW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            grant        <= '0;
            rr_ptr       <= '0;
            watchdog     <= '0;
            ack          <= '0;
            result       <= '0;
            err          <= 1'b0;
            busy         <= 1'b0;
            mult_en      <= 1'b0;
            multiplicant <= '0;
            multiplier   <= '0;
        end else begin
            mult_en <= 1'b0;
            ack     <= '0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        grant        <= pick;
                        multiplicant <= op_a[pick*WIDTH +: WIDTH];
                        multiplier   <= op_b[pick*WIDTH +: WIDTH];
                        mult_en      <= 1'b1;
                        busy         <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    watchdog <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (mult_done) begin
                        result     <= mult_product;
                        err        <= 1'b0;
                        ack[grant] <= 1'b1;
                        state      <= S_RESP;
                    end else if (watchdog == WD_LAST) begin
                        result     <= '0;
                        err        <= 1'b1;
                        ack[grant] <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                S_RESP: begin
                    rr_ptr   <= (grant == LAST_CLIENT) ? '0 : grant + 1'b1;
                    watchdog <= '0;
                    state    <= S_DRAIN;
                end
                S_DRAIN: begin
                    // A hung multiplier never raised done, so there is nothing to drain.
                    if (err || !mult_done || watchdog == WD_LAST) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter
//   Directed bench for mult_share_arbiter with a behavioural serial
//   multiplier and an expected-job queue filled when requests are driven.
module tb_mult_share_arbiter;

    localparam int WIDTH   = 4;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  ack;
    logic [7:0]  result;
    logic        err;
    logic        busy;
    logic        mult_en;
    logic [3:0]  multiplicant;
    logic [3:0]  multiplier;
    logic [7:0]  mult_product;
    logic        mult_done;

    always #5 clk = ~clk;

    mult_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
        .ack(ack), .result(result), .err(err), .busy(busy), .mult_en(mult_en),
        .multiplicant(multiplicant), .multiplier(multiplier),
        .mult_product(mult_product), .mult_done(mult_done)
    );

    typedef struct {
        int client;
        int a;
        int b;
        int res;
        int err;
    } job_t;

    job_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0, en_seen = 0, ack_seen = 0;
    int   en_cyc = 0, ack_cyc = 0, done_cyc = 0;
    logic done_q = 1'b0;
    bit   hang = 1'b0;
    int   hold_extra = 0;
    int   tb_rr = 0;
    int   a_of[4];
    int   b_of[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Behavioural serial multiplier: done rises LAT edges after the enable and
    // stays up for 1+hold_extra cycles; in hang mode done never rises.
    int         m_cnt;
    bit         m_busy;
    int         m_hold;
    logic [7:0] m_prod;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt        <= 0;
            m_busy       <= 1'b0;
            m_hold       <= 0;
            m_prod       <= '0;
            mult_done    <= 1'b0;
            mult_product <= '0;
        end else if (mult_en) begin
            m_busy    <= 1'b1;
            m_cnt     <= LAT;
            m_prod    <= {4'b0, multiplicant} * {4'b0, multiplier};
            mult_done <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt <= 1) begin
                m_busy <= 1'b0;
                if (!hang) begin
                    mult_done    <= 1'b1;
                    mult_product <= m_prod;
                    m_hold       <= hold_extra;
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (mult_done) begin
            if (m_hold == 0) mult_done <= 1'b0;
            else             m_hold    <= m_hold - 1;
        end
    end

    // Monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        job_t e;
        if (reset) begin
            cyc++;
            if (mult_done && !done_q) done_cyc = cyc;
            done_q = mult_done;
            if (mult_en) begin
                en_seen++;
                en_cyc = cyc;
                chk("en_busy", 32'(busy), 32'd1);
                chk("en_done_low", 32'(mult_done), 32'd0);
                if (sb.size() > 0) begin
                    chk("operand_a", 32'(multiplicant), sb[0].a);
                    chk("operand_b", 32'(multiplier), sb[0].b);
                end
            end
            if (ack !== 4'b0) begin
                ack_seen++;
                ack_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_onehot", 32'(ack), 32'(1 << e.client));
                    chk("result", 32'(result), e.res);
                    chk("err", 32'(err), e.err);
                end
            end
        end
    end

    task automatic set_ops(input int c, input int a, input int b);
        a_of[c] = a;
        b_of[c] = b;
        op_a[c*4 +: 4] = 4'(a);
        op_b[c*4 +: 4] = 4'(b);
    endtask

    // Expected service order for a held request mask, from the bench's own pointer.
    task automatic push_jobs(input logic [3:0] mask, input int n);
        int   p;
        job_t j;
        p = tb_rr;
        for (int k = 0; k < n; k++) begin
            int g;
            g = -1;
            for (int s = 0; s < 4; s++) begin
                if (g < 0 && mask[(p + s) % 4]) g = (p + s) % 4;
            end
            j.client = g;
            j.a      = a_of[g];
            j.b      = b_of[g];
            j.res    = hang ? 0 : a_of[g] * b_of[g];
            j.err    = hang ? 1 : 0;
            sb.push_back(j);
            p = (g + 1) % 4;
        end
        tb_rr = p;
    endtask

    task automatic wait_acks(input int target, input int budget);
        int k;
        k = 0;
        while (ack_seen < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (ack_seen < target) chk("ack_wait_expired", 32'(ack_seen), 32'(target));
    endtask

    task automatic wait_en(input int target, input int budget);
        int k;
        k = 0;
        while (en_seen < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (en_seen < target) chk("en_wait_expired", 32'(en_seen), 32'(target));
    endtask

    task automatic run(input logic [3:0] mask, input int n);
        int target;
        @(negedge clk);
        push_jobs(mask, n);
        target = ack_seen + n;
        req = mask;
        wait_acks(target, n * (2 * TIMEOUT + 40));
        @(negedge clk);
        req = 4'b0;
    endtask

    initial begin
        int e0, s0;
        reset = 1'b0;
        req   = '0;
        op_a  = '0;
        op_b  = '0;
        for (int i = 0; i < 4; i++) begin
            a_of[i] = 0;
            b_of[i] = 0;
        end
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_en", 32'(mult_en), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Single job on client 2.
        set_ops(2, 13, 11);
        e0 = en_seen;
        run(4'b0100, 1);
        chk("t2_en_count", 32'(en_seen - e0), 32'd1);
        chk("t2_done_to_ack", 32'(ack_cyc - done_cyc), 32'd1);

        // Reset in the middle of a job; the abandoned job must never ack.
        set_ops(0, 5, 6);
        hang = 1'b1;
        e0 = en_seen;
        @(negedge clk);
        req = 4'b0001;
        wait_en(e0 + 1, 20);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t1_ack", 32'(ack), 32'd0);
        chk("t1_result", 32'(result), 32'd0);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_en", 32'(mult_en), 32'd0);
        chk("t1_multiplicant", 32'(multiplicant), 32'd0);
        chk("t1_multiplier", 32'(multiplier), 32'd0);
        req = 4'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        hang  = 1'b0;
        tb_rr = 0;
        s0 = ack_seen;
        repeat (30) @(negedge clk);
        chk("t1_no_ack", 32'(ack_seen), 32'(s0));
        chk("t1_idle", 32'(busy), 32'd0);

        // Round robin with all clients requesting: 0,1,2,3,0.
        set_ops(0, 3, 5);
        set_ops(1, 7, 9);
        set_ops(2, 12, 4);
        set_ops(3, 15, 14);
        e0 = en_seen;
        run(4'b1111, 5);
        chk("t3_en_count", 32'(en_seen - e0), 32'd5);

        // Corners and random operands.
        set_ops(0, 0, 9);
        run(4'b0001, 1);
        set_ops(1, 15, 15);
        run(4'b0010, 1);
        set_ops(2, 7, 0);
        run(4'b0100, 1);
        for (int k = 0; k < 50; k++) begin
            int c;
            c = k % 4;
            set_ops(c, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            run(4'(1 << c), 1);
        end

        // Multiplier hang: timeout ack with err, then a normal job.
        hang = 1'b1;
        set_ops(1, 9, 9);
        run(4'b0010, 1);
        chk("t5_gap", 32'(ack_cyc - en_cyc), 32'(TIMEOUT + 1));
        hang = 1'b0;
        run(4'b0010, 1);

        // Sticky done: the next job may only start once done has dropped.
        hold_extra = 6;
        set_ops(1, 6, 7);
        set_ops(2, 11, 13);
        e0 = en_seen;
        run(4'b0110, 2);
        s0 = ack_seen;
        repeat (30) @(negedge clk);
        hold_extra = 0;
        chk("t6_no_extra_ack", 32'(ack_seen), 32'(s0));
        chk("t6_en_count", 32'(en_seen - e0), 32'd2);

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
